// File: rtl/completion_collector.sv
// completion_collector: per-FU completion FIFOs merged into one valid/ready stream toward the ROB
// Ports: clk/rst (sync, active-high); fu_out_inst_valid/fu_out_inst_ids per-FU completion pulses;
// fu_cmpl_full per-FU almost-full backpressure; cmpl_valid/cmpl_ready/cmpl_inst_id/cmpl_fu output
// stream; cmpl_overflow sticky drop flag.
// Optional: define CMPL_BYPASS_EN to let a completion arriving at an empty FIFO leave in the same cycle.
module completion_collector #(
  parameter int INST_ID_BITS = 6,
  parameter int FU_COUNT = 4,
  parameter int FUC_BITS = 2,
  parameter int CQ_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic fu_out_inst_valid [FU_COUNT],
  input  logic [INST_ID_BITS-1:0] fu_out_inst_ids [FU_COUNT],
  output logic fu_cmpl_full [FU_COUNT],
  output logic cmpl_valid,
  input  logic cmpl_ready,
  output logic [INST_ID_BITS-1:0] cmpl_inst_id,
  output logic [FUC_BITS-1:0] cmpl_fu,
  output logic cmpl_overflow
);
  localparam int PW = $clog2(CQ_DEPTH);
  localparam int CW = PW + 1;
  logic [FU_COUNT-1:0] cand, drop;
  logic [INST_ID_BITS-1:0] head [FU_COUNT];
  logic [FUC_BITS-1:0] rr_ptr, lock_idx, scan, grant;
  logic lock_v, found, fire;
  for (genvar i = 0; i < FU_COUNT; i++) begin : g_fu
    logic [INST_ID_BITS-1:0] mem [CQ_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic empty, full, pop, fifo_pop, we;
    assign empty = count == '0;
    assign full = count == CW'(CQ_DEPTH);
`ifdef CMPL_BYPASS_EN
    assign cand[i] = !empty || fu_out_inst_valid[i];
    assign head[i] = empty ? fu_out_inst_ids[i] : mem[rd_ptr];
`else
    assign cand[i] = !empty;
    assign head[i] = mem[rd_ptr];
`endif
    assign pop = fire && grant == FUC_BITS'(i);
    assign fifo_pop = pop && !empty;
    // a bypassed completion (empty FIFO, popped this cycle) is never written
    assign we = fu_out_inst_valid[i] && !(empty && pop) && (!full || pop);
    assign drop[i] = fu_out_inst_valid[i] && full && !pop;
    assign fu_cmpl_full[i] = count >= CW'(CQ_DEPTH - 1);
    always_ff @(posedge clk) begin
      if (rst) begin
        count <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (we) begin
          mem[wr_ptr] <= fu_out_inst_ids[i];
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (fifo_pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(we) - CW'(fifo_pop);
      end
    end
  end
  always_comb begin
    scan = '0;
    found = 1'b0;
    for (int k = 0; k < FU_COUNT; k++)
      if (!found && cand[(int'(rr_ptr) + k) % FU_COUNT]) begin
        found = 1'b1;
        scan = FUC_BITS'((int'(rr_ptr) + k) % FU_COUNT);
      end
  end
  // a stalled grant stays pinned so the presented completion cannot change under backpressure
  assign grant = lock_v ? lock_idx : scan;
  assign cmpl_valid = lock_v || found;
  assign fire = cmpl_valid && cmpl_ready;
  assign cmpl_inst_id = cmpl_valid ? head[grant] : '0;
  assign cmpl_fu = cmpl_valid ? grant : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      lock_v <= 1'b0;
      lock_idx <= '0;
      cmpl_overflow <= 1'b0;
    end else begin
      lock_v <= cmpl_valid && !cmpl_ready;
      lock_idx <= grant;
      if (fire) rr_ptr <= grant == FUC_BITS'(FU_COUNT - 1) ? '0 : grant + 1'b1;
      if (|drop) cmpl_overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_completion_collector.sv
// tb_completion_collector: scoreboard bench for completion_collector
module tb_completion_collector;
`ifdef CMPL_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef struct packed {logic [5:0] id; logic [1:0] fu;} exp_t;
  logic clk = 1'b0;
  logic rst;
  logic fu_v [4];
  logic [5:0] fu_id [4];
  logic fu_full [4];
  logic cmpl_valid, cmpl_ready, cmpl_overflow;
  logic [5:0] cmpl_inst_id;
  logic [1:0] cmpl_fu;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  completion_collector dut (
    .clk(clk),
    .rst(rst),
    .fu_out_inst_valid(fu_v),
    .fu_out_inst_ids(fu_id),
    .fu_cmpl_full(fu_full),
    .cmpl_valid(cmpl_valid),
    .cmpl_ready(cmpl_ready),
    .cmpl_inst_id(cmpl_inst_id),
    .cmpl_fu(cmpl_fu),
    .cmpl_overflow(cmpl_overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (!rst && cmpl_valid && cmpl_ready) begin
      if (q.size() == 0) chk("extra_completion", 32'(q.size()), 1);
      else begin
        e = q.pop_front();
        chk("sb_id", 32'(cmpl_inst_id), 32'(e.id));
        chk("sb_fu", 32'(cmpl_fu), 32'(e.fu));
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    for (int i = 0; i < 4; i++) begin
      fu_v[i] = 1'b0;
      fu_id[i] = '0;
    end
  endtask
  task automatic pulse(input int f, input int id);
    fu_v[f] = 1'b1;
    fu_id[f] = 6'(id);
    tick;
    fu_v[f] = 1'b0;
  endtask
  task automatic expect_c(input int id, input int f);
    q.push_back('{id: 6'(id), fu: 2'(f)});
  endtask
  task automatic drain;
    for (int i = 0; i < 40 && q.size() != 0; i++) tick;
    chk("drain_left", 32'(q.size()), 0);
  endtask
  task automatic held(input string tag, input int id, input int f);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(cmpl_valid), 1);
    chk({tag, "_id"}, 32'(cmpl_inst_id), 32'(id));
    chk({tag, "_fu"}, 32'(cmpl_fu), 32'(f));
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    cmpl_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fu_v[i] = 1'b1;
      fu_id[i] = 6'(i + 1);
    end
    tick;
    tick;
    rst = 1'b0;
    idle;
    @(negedge clk);
    chk("rst_valid", 32'(cmpl_valid), 0);
    chk("rst_ovf", 32'(cmpl_overflow), 0);
    for (int i = 0; i < 4; i++) chk($sformatf("rst_full%0d", i), 32'(fu_full[i]), 0);
    chk("rst_id", 32'(cmpl_inst_id), 0);
    cmpl_ready = 1'b1;
    tick;
    tick;
    @(negedge clk);
    chk("rst_leak", 32'(cmpl_valid), 0);
    tick;
    for (int i = 0; i < 4; i++) begin
      expect_c(10 + i, i);
      fu_v[i] = 1'b1;
      fu_id[i] = 6'(10 + i);
    end
    @(negedge clk);
    chk("sim_latency", 32'(cmpl_valid), 32'(BYP));
    tick;
    idle;
    drain;
    cmpl_ready = 1'b0;
    fu_v[2] = 1'b1;
    fu_id[2] = 6'd5;
    tick;
    idle;
    fu_v[0] = 1'b1;
    fu_id[0] = 6'd7;
    held("stall1", 5, 2);
    tick;
    idle;
    held("stall2", 5, 2);
    tick;
    held("stall3", 5, 2);
    expect_c(5, 2);
    expect_c(7, 0);
    cmpl_ready = 1'b1;
    drain;
    cmpl_ready = 1'b0;
    pulse(1, 20);
    pulse(1, 21);
    @(negedge clk);
    chk("full_at2", 32'(fu_full[1]), 0);
    tick;
    pulse(1, 22);
    @(negedge clk);
    chk("full_at3", 32'(fu_full[1]), 1);
    chk("full_other", 32'(fu_full[0]), 0);
    tick;
    pulse(1, 23);
    @(negedge clk);
    chk("ovf_at4", 32'(cmpl_overflow), 0);
    tick;
    pulse(1, 24);
    @(negedge clk);
    chk("ovf_at5", 32'(cmpl_overflow), 1);
    chk("full_at5", 32'(fu_full[1]), 1);
    tick;
    for (int i = 0; i < 4; i++) expect_c(20 + i, 1);
    cmpl_ready = 1'b1;
    drain;
    @(negedge clk);
    chk("ovf_sticky", 32'(cmpl_overflow), 1);
    tick;
    cmpl_ready = 1'b0;
    pulse(3, 70);
    tick;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 32'(cmpl_valid), 0);
    chk("midrst_ovf", 32'(cmpl_overflow), 0);
    cmpl_ready = 1'b1;
    tick;
    tick;
    @(negedge clk);
    chk("midrst_leak", 32'(cmpl_valid), 0);
    tick;
    cmpl_ready = 1'b0;
    for (int i = 0; i < 4; i++) pulse(1, 30 + i);
    for (int i = 0; i < 5; i++) expect_c(30 + i, 1);
    fu_v[1] = 1'b1;
    fu_id[1] = 6'd34;
    cmpl_ready = 1'b1;
    tick;
    idle;
    @(negedge clk);
    chk("pushpop_full_ovf", 32'(cmpl_overflow), 0);
    drain;
    chk("pushpop_ovf_end", 32'(cmpl_overflow), 0);
    expect_c(60, 2);
    pulse(2, 60);
    drain;
    cmpl_ready = 1'b0;
    fu_v[3] = 1'b1;
    fu_id[3] = 6'd40;
    fu_v[0] = 1'b1;
    fu_id[0] = 6'd50;
    tick;
    fu_id[3] = 6'd41;
    fu_id[0] = 6'd51;
    tick;
    idle;
    expect_c(40, 3);
    expect_c(50, 0);
    expect_c(41, 3);
    expect_c(51, 0);
    cmpl_ready = 1'b1;
    drain;
`ifdef CMPL_BYPASS_EN
    expect_c(9, 2);
    fu_v[2] = 1'b1;
    fu_id[2] = 6'd9;
    held("byp_same", 9, 2);
    tick;
    idle;
    @(negedge clk);
    chk("byp_empty", 32'(cmpl_valid), 0);
    tick;
    cmpl_ready = 1'b0;
    fu_v[2] = 1'b1;
    fu_id[2] = 6'd9;
    held("byp_stall", 9, 2);
    tick;
    idle;
    held("byp_hold", 9, 2);
    expect_c(9, 2);
    cmpl_ready = 1'b1;
    drain;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
